// File: rtl/alu_muldiv_pipe_pkg.sv
// rtl/alu_muldiv_pipe_pkg.sv - opcodes, FSM encoding and width limits for alu_muldiv_pipe
package alu_muldiv_pipe_pkg;

  localparam int WIDTH_MIN = 8;
  localparam int WIDTH_MAX = 64;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_NOR   = 4'd13;
  localparam logic [3:0] OP_REMU  = 4'd14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-step-per-cycle shift-add multiplier / restoring divider
module muldiv_iter
  import alu_muldiv_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             sel_hi_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int CW = $clog2(WIDTH + 1);

  // hi holds the upper product / partial remainder, lo the multiplier / quotient
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
  logic             is_div_q, sel_hi_q;
  logic [WIDTH:0]   sum, rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum    = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    diff   = WIDTH'(rem_sh - {1'b0, b_q});
    ge     = rem_sh >= {1'b0, b_q};
    hi_d   = sum[WIDTH:1];
    lo_d   = {sum[0], lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      hi_d = ge ? diff : rem_sh[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge};
    end
  end

  // Result is taken from the final step's next-state so it registers on the done edge
  assign res_o  = sel_hi_q ? hi_d : lo_d;
  assign done_o = (cnt_q == CW'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
    end else if (start_i) begin
      cnt_q    <= CW'(WIDTH);
      hi_q     <= '0;
      lo_q     <= a_i;
      b_q      <= b_i;
      is_div_q <= is_div_i;
      sel_hi_q <= sel_hi_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: rtl/alu_muldiv_pipe.sv
// rtl/alu_muldiv_pipe.sv - single-cycle ALU with iterative MUL/MULHU/DIVU/REMU
module alu_muldiv_pipe
  import alu_muldiv_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [3:0]       i_ALUctrl,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_Y,
  output logic             o_Zero,
  output logic             o_Carry,
  output logic             o_Ovf
);

  localparam int SHW = $clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("alu_muldiv_pipe: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d, alu_y, md_res;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, valid_q, valid_d;
  logic             alu_c, alu_v, accept, iter_op, md_done;
  logic [SHW-1:0]   sham;
  logic [WIDTH:0]   add_r, sub_r;

  assign o_ready = (state_q == ST_IDLE);
  assign accept  = i_valid && o_ready;
  assign iter_op = is_iter_op(i_ALUctrl);
  assign sham    = i_B[SHW-1:0];
  assign add_r   = {1'b0, i_A} + {1'b0, i_B};
  assign sub_r   = {1'b0, i_A} + {1'b0, ~i_B} + (WIDTH + 1)'(1);

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (i_ALUctrl)
      OP_AND: alu_y = i_A & i_B;
      OP_OR:  alu_y = i_A | i_B;
      OP_XOR: alu_y = i_A ^ i_B;
      OP_NOR: alu_y = ~(i_A | i_B);
      OP_SLL: alu_y = i_A << sham;
      OP_SRL: alu_y = i_A >> sham;
      OP_SRA: alu_y = $unsigned($signed(i_A) >>> sham);
      OP_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
      OP_ADD: begin
        alu_y = add_r[WIDTH-1:0];
        alu_c = add_r[WIDTH];
        alu_v = (i_A[WIDTH-1] == i_B[WIDTH-1]) && (add_r[WIDTH-1] != i_A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y = sub_r[WIDTH-1:0];
        alu_c = sub_r[WIDTH];
        alu_v = (i_A[WIDTH-1] != i_B[WIDTH-1]) && (sub_r[WIDTH-1] != i_A[WIDTH-1]);
      end
      default: alu_y = '0;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .start_i  (accept && iter_op),
    .is_div_i ((i_ALUctrl == OP_DIVU) || (i_ALUctrl == OP_REMU)),
    .sel_hi_i ((i_ALUctrl == OP_MULHU) || (i_ALUctrl == OP_REMU)),
    .a_i      (i_A),
    .b_i      (i_B),
    .done_o   (md_done),
    .res_o    (md_res)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && iter_op) begin
          state_d = ST_ITER;
        end else if (accept) begin
          y_d     = alu_y;
          carry_d = alu_c;
          ovf_d   = alu_v;
          valid_d = 1'b1;
        end
      end
      ST_ITER: begin
        if (md_done) begin
          state_d = ST_IDLE;
          y_d     = md_res;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    zero_d = (y_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_Y     = y_q;
  assign o_Zero  = zero_q;
  assign o_Carry = carry_q;
  assign o_Ovf   = ovf_q;

endmodule

// File: tb/tb_alu_muldiv_pipe.sv
// tb/tb_alu_muldiv_pipe.sv - randomized self-checking bench for alu_muldiv_pipe
module tb_alu_muldiv_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic [3:0]   ctrl = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         o_ready, o_valid, o_Zero, o_Carry, o_Ovf;
  logic [W-1:0] o_Y;

  int n_checks = 0;
  int n_fail = 0;

  logic [3:0] single_ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd13, 4'd15};

  alu_muldiv_pipe #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (valid),
    .i_ALUctrl (ctrl),
    .i_A       (a),
    .i_B       (b),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_Y       (o_Y),
    .o_Zero    (o_Zero),
    .o_Carry   (o_Carry),
    .o_Ovf     (o_Ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {carry, ovf, y} from plain arithmetic on the operands
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0]        r;
    logic               c, v;
    logic [63:0]        p;
    longint             sx, sy, s;
    logic signed [31:0] xs;
    int unsigned        sh;
    c = 1'b0; v = 1'b0; r = '0;
    sx = $signed(x); sy = $signed(y); xs = x;
    sh = y % 32;
    p = 64'(x) * 64'(y);
    case (op)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin
        r = x + y;
        c = (64'(x) + 64'(y)) > 64'hFFFF_FFFF;
        s = sx + sy;
        v = (s != longint'($signed(r)));
      end
      4'd3: r = x ^ y;
      4'd5: r = x << sh;
      4'd6: begin
        r = x - y;
        c = (x >= y);
        s = sx - sy;
        v = (s != longint'($signed(r)));
      end
      4'd7: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd8: r = x >> sh;
      4'd9: r = xs >>> sh;
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      4'd12: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd13: r = ~(x | y);
      4'd14: r = (y == 0) ? x : x % y;
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (op == 4'd10 || op == 4'd11 || op == 4'd12 || op == 4'd14) ? W : 0;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_y"}, o_Y, 0);
    check({tag, "_zero"}, o_Zero, 1);
    check({tag, "_carry"}, o_Carry, 0);
    check({tag, "_ovf"}, o_Ovf, 0);
    check({tag, "_ready"}, o_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [33:0] e;
    int          cnt, busy_err;
    e = model(op, x, y);
    @(negedge clk);
    check({tag, "_ready_in"}, o_ready, 1);
    valid = 1'b1; ctrl = op; a = x; b = y;
    @(posedge clk);
    #1;
    valid = 1'b0; ctrl = 4'($urandom); a = $urandom; b = $urandom;
    @(negedge clk);
    cnt = 0; busy_err = 0;
    while (!o_valid && cnt < 100) begin
      if (o_ready) busy_err++;
      @(negedge clk);
      cnt++;
    end
    check({tag, "_lat"}, cnt, exp_lat(op));
    if (exp_lat(op) > 0) check({tag, "_busy"}, busy_err, 0);
    check({tag, "_y"}, o_Y, e[31:0]);
    check({tag, "_zero"}, o_Zero, (e[31:0] == 0));
    check({tag, "_carry"}, o_Carry, e[33]);
    check({tag, "_ovf"}, o_Ovf, e[32]);
    @(negedge clk);
    check({tag, "_strobe"}, o_valid, 0);
    check({tag, "_hold"}, o_Y, e[31:0]);
  endtask

  initial begin
    logic [33:0] exp_q [$];
    logic [33:0] e;
    logic [3:0]  op;
    logic [31:0] x, y;
    int          cnt, seen;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'h1);
    run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h1);
    run_op("sub_borrow", 4'd6, 32'd3, 32'd5);
    run_op("sub_ovf", 4'd6, 32'h8000_0000, 32'h1);
    run_op("mul", 4'd10, 32'h0001_0000, 32'h0001_0000);
    run_op("mulhu", 4'd11, 32'h0001_0000, 32'h0001_0000);
    run_op("divu", 4'd12, 32'd100, 32'd7);
    run_op("remu", 4'd14, 32'd100, 32'd7);
    run_op("divu0", 4'd12, 32'd5, 32'd0);
    run_op("remu0", 4'd14, 32'd5, 32'd0);
    run_op("sra", 4'd9, 32'h8000_0000, 32'h21);
    run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'h1);
    run_op("op4", 4'd4, 32'hDEAD_BEEF, 32'h1234_5678);
    run_op("op15", 4'd15, 32'hDEAD_BEEF, 32'h1234_5678);

    // valid held high through a divide, then a single-cycle op in the result cycle
    @(negedge clk);
    valid = 1'b1; ctrl = 4'd12; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1;
    ctrl = 4'd2; a = 32'd3; b = 32'd4;
    @(negedge clk);
    cnt = 0;
    while (!o_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("held_lat", cnt, W);
    check("held_y", o_Y, 14);
    check("held_ready", o_ready, 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    check("follow_valid", o_valid, 1);
    check("follow_y", o_Y, 7);
    @(negedge clk);
    check("follow_strobe", o_valid, 0);

    // back-to-back single-cycle stream
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        check("b2b_valid", o_valid, 1);
        check("b2b_y", o_Y, e[31:0]);
        check("b2b_flags", {o_Carry, o_Ovf}, e[33:32]);
      end
      op = single_ops[$urandom_range(0, 11)];
      x = $urandom; y = $urandom;
      valid = 1'b1; ctrl = op; a = x; b = y;
      exp_q.push_back(model(op, x, y));
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    check("b2b_last_valid", o_valid, 1);
    check("b2b_last_y", o_Y, e[31:0]);

    // reset 10 cycles into a multiply
    @(negedge clk);
    valid = 1'b1; ctrl = 4'd10; a = $urandom | 32'h1; b = $urandom | 32'h1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    check("abort_no_valid", seen, 0);

    // reset wins over an accept on the same edge
    @(negedge clk);
    valid = 1'b1; ctrl = 4'd11; a = $urandom; b = $urandom; rst_n = 1'b0;
    @(posedge clk);
    #1;
    valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_prio");
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    check("rst_prio_no_valid", seen, 0);

    // randomized operations with boundary-biased operands
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: x = 32'hFFFF_FFFF;
        2: x = 32'h8000_0000;
        3: y = 32'($urandom_range(1, 40));
        default: ;
      endcase
      run_op("rnd", op, x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_pipe.md
ALU_MULDIV_PIPE -- requirements
Module: alu_muldiv_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: i_clk clocks all state, and i_rst_n is sampled only on rising i_clk.
REQ-002 Parameter WIDTH, default 32, SHALL set the datapath width; legal values are 8..64.
REQ-003 Ports SHALL be:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: synchronous reset, active low.
- i_valid, input, 1: a request is present.
- i_ALUctrl, input, 4: opcode.
- i_A, input, WIDTH: operand A.
- i_B, input, WIDTH: operand B.
- o_ready, output, 1: the block can accept a request.
- o_valid, output, 1: one-cycle result strobe.
- o_Y, output, WIDTH: result.
- o_Zero, output, 1: o_Y == 0.
- o_Carry, output, 1: carry-out of ADD/SUB.
- o_Ovf, output, 1: signed overflow of ADD/SUB.

Function
REQ-004 A request SHALL be accepted on a rising edge where i_valid=1 and o_ready=1; operands and opcode are captured at that edge.
REQ-005 Opcodes SHALL be:
- 0 AND, 1 OR, 2 ADD, 3 XOR, 5 SLL, 6 SUB, 7 SLT (signed, result 1/0), 8 SRL, 9 SRA, 13 NOR: single-cycle.
- 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 14 REMU: iterative.
- 4 and 15: single-cycle, o_Y=0.
REQ-006 Shift amount SHALL be i_B[clog2(WIDTH)-1:0]; upper bits of i_B are ignored.
REQ-007 Single-cycle ops SHALL have latency 1: accept at edge k gives o_valid=1 for exactly the cycle after edge k.
REQ-008 Iterative ops SHALL use one shift-add (multiply) or one restoring-subtract (divide) step per cycle, WIDTH steps in total: accept at edge k gives o_valid=1 for exactly the cycle after edge k+WIDTH.
REQ-009 FSM states SHALL be IDLE and ITER:
- IDLE to ITER on accepting an iterative op, with the step counter loaded to WIDTH.
- In ITER the counter decrements each edge.
- ITER to IDLE on the edge where the counter goes 1 to 0; o_valid is set on that same edge.
REQ-010 o_ready SHALL be 1 exactly when the state is IDLE; i_valid in ITER is ignored and no request is queued.
REQ-011 A new request MAY be accepted in the same cycle o_valid=1; back-to-back single-cycle ops SHALL sustain one result per cycle.
REQ-012 o_Y and the flags SHALL be registered and SHALL hold their value until the next o_valid.
REQ-013 o_Carry and o_Ovf SHALL be valid only for ADD/SUB and SHALL be 0 for all other ops; SUB carry means no borrow (A>=B unsigned).
REQ-014 Divide by zero SHALL give: DIVU o_Y = all ones, REMU o_Y = i_A, with full WIDTH latency and no error flag.
REQ-015 MULHU and MUL SHALL produce their results from the same 2*WIDTH-bit unsigned product.

Reset
REQ-016 When i_rst_n=0 at an edge, the block SHALL set state=IDLE, counter=0, o_valid=0, o_Y=0, o_Zero=1, o_Carry=0, o_Ovf=0; o_ready is 1 in the following cycle.
REQ-017 Reset during ITER SHALL abort the operation, with no o_valid for the aborted request.
REQ-018 Reset SHALL take priority over an accept on the same edge.

Structure
REQ-019 A shared package SHALL hold the opcode constants, the FSM state encoding, and the WIDTH legality limits.
REQ-020 The iterative multiplier/divider SHALL be a sub-module, muldiv_iter, with start/done handshake; combinational single-cycle ops stay in the top level.

Verification (WIDTH=32)
REQ-021 ADD 0xFFFFFFFF+0x00000001 SHALL give, 1 cycle later: o_Y=0, o_Zero=1, o_Carry=1, o_Ovf=0; ADD 0x7FFFFFFF+1 SHALL give o_Y=0x80000000, o_Ovf=1.
REQ-022 MUL 0x0001_0000*0x0001_0000 SHALL give o_Y=0 with o_valid exactly 32 edges after accept; MULHU of the same operands SHALL give o_Y=0x00000001.
REQ-023 DIVU 100/7 SHALL give 14; REMU 100/7 SHALL give 2; DIVU 5/0 SHALL give 0xFFFFFFFF; REMU 5/0 SHALL give 5.
REQ-024 i_valid held high during a DIVU SHALL have no effect until o_ready=1; a single-cycle request accepted in the o_valid cycle SHALL produce its own o_valid one cycle later.
REQ-025 i_rst_n pulsed low 10 cycles into a MUL SHALL cause no o_valid, all outputs at reset values, and o_ready=1 on the next cycle.
REQ-026 SRA 0x80000000 by i_B=0x21 SHALL use shift amount 1 and give 0xC0000000; SLT -1,1 SHALL give 1.
